// File: rtl/bmi_pwm_ramp_ctrl_if.sv
// Panel/bridge-side signal bundle for the BMI-driven PWM motor controller.
// master = rider panel / supervisor, slave = the controller itself.
interface bmi_pwm_ramp_ctrl_if;
    logic       start;
    logic [7:0] in_height;
    logic [6:0] in_weight;
    logic [1:0] mode;
    logic       dir_req;
    logic       fault_in;
    logic       fault_clr;
    logic       pdcm;
    logic       dir;
    logic       fault_out;
    logic [1:0] leds;
    logic       busy;
    logic [5:0] bmi;
    logic [3:0] speed_level;

    modport master (
        output start, in_height, in_weight, mode, dir_req, fault_in, fault_clr,
        input  pdcm, dir, fault_out, leds, busy, bmi, speed_level
    );

    modport slave (
        input  start, in_height, in_weight, mode, dir_req, fault_in, fault_clr,
        output pdcm, dir, fault_out, leds, busy, bmi, speed_level
    );
endinterface

// File: rtl/bmi_pwm_ramp_ctrl.sv
// Exercise-bike motor driver: sequential BMI divider -> speed level -> target duty,
// soft-ramped PWM with latched faults and zero-duty direction reversal.
module bmi_pwm_ramp_ctrl #(
    parameter int PRESCALE  = 5000,
    parameter int PWM_BITS  = 8,
    parameter int DUTY_STEP = 25,
    parameter int RAMP_STEP = 5,
    parameter int BMI_MIN   = 15,
    parameter int BMI_MAX   = 30,
    parameter int SPEED_MIN = 1,
    parameter int SPEED_MAX = 10
) (
    input  logic               clk,
    input  logic               reset,
    bmi_pwm_ramp_ctrl_if.slave bus
);
    localparam int         PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int         DUTY_MAX  = (1 << PWM_BITS) - 1;
    localparam int         DIV_BITS  = 21;
    localparam logic [4:0] DIV_ITERS = 5'd21;
    localparam logic [4:0] CALC_LAST = 5'd31;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_RUN, S_DIR_CHG, S_FAULT} state_t;
    typedef logic [PWM_BITS-1:0] duty_t;

    state_t              state_q;
    logic                fsync1_q, fsync2_q;
    logic [PS_W-1:0]     presc_q;
    duty_t               pwm_cnt_q;
    duty_t               duty_q, target_q;
    logic                pdcm_q, dir_q, fault_out_q, busy_q, bmi_valid_q;
    logic [5:0]          bmi_q;
    logic [3:0]          level_q;
    logic [4:0]          cnt_q;
    logic [DIV_BITS-1:0] dvd_q;
    logic [15:0]         dvs_q, rem_q;
    logic                hzero_q;
    logic [1:0]          mode_q;

    logic                tick, boundary;
    logic [DIV_BITS-1:0] dvd_ld;
    logic [15:0]         dvs_ld;
    logic [16:0]         rem_sh;
    logic                rem_ge;
    logic [15:0]         rem_sub;
    logic [5:0]          bmi_d;
    logic [3:0]          level_d;
    duty_t               target_d, tgt_eff, ramp_d;
    int                  lvl_int, tgt_int;

    function automatic int map_level(input int b, input logic [1:0] m);
        int l;
        if (b <= BMI_MIN)      l = SPEED_MAX;
        else if (b >= BMI_MAX) l = SPEED_MIN;
        else l = SPEED_MAX - ((b - BMI_MIN) * (SPEED_MAX - SPEED_MIN)) / (BMI_MAX - BMI_MIN);
        if (m == 2'b01)      l = (l - 2 < SPEED_MIN) ? SPEED_MIN : l - 2;
        else if (m == 2'b10) l = (l + 2 > SPEED_MAX) ? SPEED_MAX : l + 2;
        return l;
    endfunction

    assign tick     = (presc_q == PS_W'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt_q == '1);
    assign dvd_ld   = DIV_BITS'(bus.in_weight) * 21'd10000;
    assign dvs_ld   = 16'(bus.in_height) * 16'(bus.in_height);

    // Restoring divider step: the quotient bits shift into dvd_q behind the dividend.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[DIV_BITS-1]};
        rem_ge  = (rem_sh >= {1'b0, dvs_q});
        rem_sub = rem_sh[15:0] - dvs_q;
    end

    always_comb begin
        bmi_d    = (hzero_q || (dvd_q > 21'd63)) ? 6'd63 : dvd_q[5:0];
        lvl_int  = map_level(int'(bmi_d), mode_q);
        level_d  = 4'(lvl_int);
        tgt_int  = lvl_int * DUTY_STEP;
        target_d = duty_t'((tgt_int > DUTY_MAX) ? DUTY_MAX : tgt_int);
    end

    // Direction change drains to zero while the stored target survives for the return.
    always_comb begin
        tgt_eff = (state_q == S_DIR_CHG) ? '0 : target_q;
        ramp_d  = duty_q;
        if (tgt_eff > duty_q)
            ramp_d = (int'(tgt_eff - duty_q) > RAMP_STEP) ? duty_q + duty_t'(RAMP_STEP) : tgt_eff;
        else if (duty_q > tgt_eff)
            ramp_d = (int'(duty_q - tgt_eff) > RAMP_STEP) ? duty_q - duty_t'(RAMP_STEP) : tgt_eff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsync1_q  <= 1'b0;
            fsync2_q  <= 1'b0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            fsync1_q <= bus.fault_in;
            fsync2_q <= fsync1_q;
            presc_q  <= tick ? '0 : presc_q + 1'b1;
            if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            duty_q      <= '0;
            target_q    <= '0;
            pdcm_q      <= 1'b0;
            dir_q       <= 1'b0;
            fault_out_q <= 1'b0;
            busy_q      <= 1'b0;
            bmi_valid_q <= 1'b0;
            bmi_q       <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            hzero_q     <= 1'b0;
            mode_q      <= '0;
        end else begin
            pdcm_q <= (pwm_cnt_q < duty_q) && !fsync2_q && (state_q != S_FAULT);
            if (fsync2_q) begin
                state_q     <= S_FAULT;
                duty_q      <= '0;
                busy_q      <= 1'b0;
                fault_out_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_RUN: begin
                        if (boundary) duty_q <= ramp_d;
                        if (bus.start) begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            dvd_q   <= dvd_ld;
                            dvs_q   <= dvs_ld;
                            hzero_q <= (bus.in_height == 8'd0);
                            mode_q  <= bus.mode;
                        end else if ((state_q == S_RUN) && (bus.dir_req != dir_q)) begin
                            state_q <= S_DIR_CHG;
                        end
                    end
                    S_CALC: begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q < DIV_ITERS) begin
                            rem_q <= rem_ge ? rem_sub : rem_sh[15:0];
                            dvd_q <= {dvd_q[DIV_BITS-2:0], rem_ge};
                        end
                        // Fixed 32-clk latency regardless of the 21 real iterations.
                        if (cnt_q == CALC_LAST) begin
                            bmi_q       <= bmi_d;
                            bmi_valid_q <= 1'b1;
                            if (mode_q != 2'b11) begin
                                level_q  <= level_d;
                                target_q <= target_d;
                            end
                            busy_q  <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                    S_DIR_CHG: begin
                        if (boundary) begin
                            if (duty_q == '0) begin
                                dir_q   <= bus.dir_req;
                                state_q <= S_RUN;
                            end else begin
                                duty_q <= ramp_d;
                            end
                        end
                    end
                    S_FAULT: begin
                        duty_q <= '0;
                        if (bus.fault_clr) begin
                            fault_out_q <= 1'b0;
                            state_q     <= bmi_valid_q ? S_RUN : S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pdcm        = pdcm_q;
    assign bus.dir         = dir_q;
    assign bus.fault_out   = fault_out_q;
    assign bus.busy        = busy_q;
    assign bus.bmi         = bmi_q;
    assign bus.speed_level = level_q;
    assign bus.leds        = (state_q == S_FAULT) ? 2'b11 : {duty_q < tgt_eff, duty_q > tgt_eff};
endmodule

// File: tb/tb_bmi_pwm_ramp_ctrl.sv
// Directed + randomized bench for bmi_pwm_ramp_ctrl; duty is recovered from pdcm
// high-time per PWM period and compared with a per-period ramp model.
module tb_bmi_pwm_ramp_ctrl;
    localparam int PRESCALE  = 4;
    localparam int PWM_BITS  = 4;
    localparam int DUTY_STEP = 1;
    localparam int RAMP_STEP = 2;
    localparam int PER       = PRESCALE * (1 << PWM_BITS);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bmi_pwm_ramp_ctrl_if bus();

    bmi_pwm_ramp_ctrl #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS),
        .DUTY_STEP(DUTY_STEP),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   acc       = 0;
    int   per_cnt   = 0;
    int   meas      = 0;
    int   flips     = 0;
    int   bad_flips = 0;
    int   md        = 0;
    int   prev_lvl  = 0;
    logic prev_dir  = 1'b0;
    logic prev_pdcm = 1'b0;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    // pdcm high count over one 64-clk period equals PRESCALE * duty.
    always @(negedge clk) begin
        if (reset || cyc == 0) begin
            acc <= 0;
        end else if (cyc % PER == 0) begin
            meas    <= (acc + int'(bus.pdcm)) / PRESCALE;
            per_cnt <= per_cnt + 1;
            acc     <= 0;
        end else begin
            acc <= acc + int'(bus.pdcm);
        end
    end

    always @(negedge clk) begin
        if (!reset && (bus.dir !== prev_dir)) begin
            flips <= flips + 1;
            if (bus.pdcm !== 1'b0 || prev_pdcm !== 1'b0) bad_flips <= bad_flips + 1;
        end
        prev_dir  <= bus.dir;
        prev_pdcm <= bus.pdcm;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_bmi(input int h, input int w);
        int q;
        if (h == 0) return 63;
        q = (w * 10000) / (h * h);
        return (q > 63) ? 63 : q;
    endfunction

    function automatic int m_lvl(input int b, input int m);
        int l;
        if (b <= 15)      l = 10;
        else if (b >= 30) l = 1;
        else              l = 10 - ((b - 15) * 9) / 15;
        if (m == 1) l = (l - 2 < 1) ? 1 : l - 2;
        if (m == 2) l = (l + 2 > 10) ? 10 : l + 2;
        return l;
    endfunction

    function automatic int m_ramp(input int d, input int t);
        if (t > d) return d + ((t - d > RAMP_STEP) ? RAMP_STEP : t - d);
        if (d > t) return d - ((d - t > RAMP_STEP) ? RAMP_STEP : d - t);
        return d;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_pdcm"},  bus.pdcm, 0);
        chk({tag, "_dir"},   bus.dir, 0);
        chk({tag, "_fault"}, bus.fault_out, 0);
        chk({tag, "_leds"},  bus.leds, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_bmi"},   bus.bmi, 0);
        chk({tag, "_lvl"},   bus.speed_level, 0);
    endtask

    // Waits one period boundary, checks the duty of the finished period, then
    // advances the model duty and checks the LED direction against led_tgt.
    task automatic per_check(input string tag, input int step_tgt, input int led_tgt);
        int p0;
        int n;
        p0 = per_cnt;
        n  = 0;
        while (per_cnt == p0 && n < 4 * PER) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_to"}, (n < 4 * PER), 1);
        chk({tag, "_duty"}, meas, md);
        md = m_ramp(md, step_tgt);
        chk({tag, "_leds"}, bus.leds, {md < led_tgt, md > led_tgt});
    endtask

    task automatic do_calc(input int h, input int w, input int m, input string tag);
        int n;
        int eb;
        int el;
        bus.in_height = 8'(h);
        bus.in_weight = 7'(w);
        bus.mode      = 2'(m);
        bus.start     = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk({tag, "_busy"}, n, 32);
        eb = m_bmi(h, w);
        el = (m == 3) ? prev_lvl : m_lvl(eb, m);
        prev_lvl = el;
        chk({tag, "_bmi"}, bus.bmi, eb);
        chk({tag, "_lvl"}, bus.speed_level, el);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_height = '0;
        bus.in_weight = '0;
        bus.mode      = '0;
        bus.dir_req   = 1'b0;
        bus.fault_in  = 1'b0;
        bus.fault_clr = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        // Auto mode: bmi 22 -> level 6, duty ramps 0->2->4->6.
        per_check("p0", 0, 0);
        do_calc(170, 64, 0, "auto");
        for (int i = 0; i < 4; i++) per_check($sformatf("auto%0d", i), 6, 6);

        // Fault at duty 6.
        bus.fault_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("flt_out",  bus.fault_out, 1);
        chk("flt_pdcm", bus.pdcm, 0);
        chk("flt_leds", bus.leds, 3);
        bus.fault_clr = 1'b1;
        @(negedge clk); #1;
        bus.fault_clr = 1'b0;
        chk("flt_clr_ignored", bus.fault_out, 1);
        bus.fault_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        bus.fault_clr = 1'b1;
        @(negedge clk); #1;
        bus.fault_clr = 1'b0;
        chk("flt_cleared", bus.fault_out, 0);
        md = 0;
        for (int i = 0; i < 4; i++) per_check($sformatf("rst_ramp%0d", i), 6, 6);

        // Direction change: drain to 0, flip, ramp back.
        bus.dir_req = 1'b1;
        for (int i = 0; i < 3; i++) per_check($sformatf("dc_down%0d", i), 0, 0);
        chk("dc_dir_hold", bus.dir, 0);
        per_check("dc_flip", 0, 6);
        chk("dc_dir_new", bus.dir, 1);
        for (int i = 0; i < 4; i++) per_check($sformatf("dc_up%0d", i), 6, 6);
        chk("dc_flips", flips, 1);
        chk("dc_safe", bad_flips, 0);

        // Hold mode: bmi updates, level and target do not.
        do_calc(100, 30, 3, "hold");
        per_check("hold_p", 6, 6);

        // Clamps and saturation.
        do_calc(100, 127, 0, "sat");
        do_calc(100, 127, 1, "easy_clamp");
        do_calc(0, 50, 0, "h0");
        do_calc(140, 20, 2, "hard_clamp");

        for (int i = 0; i < 8; i++)
            do_calc(int'($urandom_range(255)), int'($urandom_range(127)),
                    int'($urandom_range(3)), $sformatf("rnd%0d", i));

        // Asynchronous reset in the middle of a calculation.
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("midcalc_busy", bus.busy, 1);
        #1 reset = 1'b1;
        #1;
        check_all_zero("async_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
